// File: rtl/sev_seg_pkg.sv
// Shared types and the hex-to-segment decode table for the seven-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package sev_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Entry h sits at bits [7h+6:7h]; glyphs run F (MSB end) down to 0 (LSB end).
   localparam logic [111:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic seg_t hex_to_seg(input logic [3:0] hex);
      return SEG_LUT[7*hex +: 7];
   endfunction

endpackage

// File: rtl/sev_seg_scan_if.sv
// Load-side and display-side signals of the seven-segment scanner.
// The master drives display data; the slave (scanner) drives the panel outputs.
interface sev_seg_scan_if
   import sev_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 8
);

   logic                    load;
   logic [4*NUM_DIGITS-1:0] value_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   en_in;
   logic [NUM_DIGITS-1:0]   an;
   seg_t                    seg;
   logic                    dp;
   logic                    frame_start;
   logic                    pending;

   modport master (
      output load, value_in, dp_in, en_in,
      input  an, seg, dp, frame_start, pending
   );

   modport slave (
      input  load, value_in, dp_in, en_in,
      output an, seg, dp, frame_start, pending
   );

endinterface

// File: rtl/sev_seg_scan_decode.sv
// Purely combinational hex nibble to active-low seven-segment pattern.
module hex_to_sev_decode
   import sev_seg_pkg::*;
(
   input  logic [3:0] i_hex,
   output seg_t       o_seg
);

   assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned data promotion.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most-significant non-zero digit.
module sev_seg_scan
   import sev_seg_pkg::*;
#(
   parameter int TICK_DIV   = 100000,
   parameter int NUM_DIGITS = 8
) (
   input logic           clk,
   input logic           reset,
   sev_seg_scan_if.slave bus
);

   localparam int                    IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int                    VW         = 4 * NUM_DIGITS;
   localparam logic [19:0]           PRESC_LAST = 20'(TICK_DIV - 1);
   localparam logic [IW-1:0]         INDEX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

   logic [19:0]           r_presc;
   logic [IW-1:0]         r_index;
   logic [VW-1:0]         r_pendVal;
   logic [NUM_DIGITS-1:0] r_pendDp;
   logic [NUM_DIGITS-1:0] r_pendEn;
   logic [VW-1:0]         r_shadowVal;
   logic [NUM_DIGITS-1:0] r_shadowDp;
   logic [NUM_DIGITS-1:0] r_shadowEn;
   logic                  r_pending;
   logic [NUM_DIGITS-1:0] r_an;
   seg_t                  r_seg;
   logic                  r_dp;
   logic                  r_frameStart;

   logic                  w_tick;
   logic                  w_wrap;
   logic [IW-1:0]         w_nextIndex;
   logic [VW-1:0]         w_nextVal;
   logic [NUM_DIGITS-1:0] w_nextDp;
   logic [NUM_DIGITS-1:0] w_nextEn;
   logic [NUM_DIGITS-1:0] w_lzMask;
   logic [NUM_DIGITS-1:0] w_lit;
   logic [3:0]            w_digit;
   seg_t                  w_digitSeg;

   assign w_tick      = (r_presc == PRESC_LAST);
   assign w_wrap      = w_tick && (r_index == INDEX_LAST);
   assign w_nextIndex = w_wrap ? '0 : (w_tick ? r_index + 1'b1 : r_index);

   // Shadow only changes on the frame boundary; a load landing on that edge bypasses pending.
   always_comb begin
      w_nextVal = r_shadowVal;
      w_nextDp  = r_shadowDp;
      w_nextEn  = r_shadowEn;
      if (w_wrap && bus.load) begin
         w_nextVal = bus.value_in;
         w_nextDp  = bus.dp_in;
         w_nextEn  = bus.en_in;
      end else if (w_wrap && r_pending) begin
         w_nextVal = r_pendVal;
         w_nextDp  = r_pendDp;
         w_nextEn  = r_pendEn;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic w_seenNz;

   always_comb begin
      w_seenNz = 1'b0;
      w_lzMask = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (w_nextVal[4*i +: 4] != 4'h0) w_seenNz = 1'b1;
         w_lzMask[i] = w_seenNz || (i == 0);
      end
   end
`else
   assign w_lzMask = '1;
`endif

   assign w_lit   = w_nextEn & w_lzMask;
   assign w_digit = w_nextVal[4*w_nextIndex +: 4];

   hex_to_sev_decode u_decode (
      .i_hex (w_digit),
      .o_seg (w_digitSeg)
   );

   // Panel outputs are registered from post-update index/shadow so they move with the index.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_presc      <= '0;
         r_index      <= '0;
         r_pendVal    <= '0;
         r_pendDp     <= '0;
         r_pendEn     <= '0;
         r_shadowVal  <= '0;
         r_shadowDp   <= '0;
         r_shadowEn   <= '0;
         r_pending    <= 1'b0;
         r_an         <= '1;
         r_seg        <= SEG_BLANK;
         r_dp         <= 1'b1;
         r_frameStart <= 1'b0;
      end else begin
         r_presc     <= w_tick ? '0 : r_presc + 20'd1;
         r_index     <= w_nextIndex;
         r_shadowVal <= w_nextVal;
         r_shadowDp  <= w_nextDp;
         r_shadowEn  <= w_nextEn;
         if (w_wrap) begin
            r_pending <= 1'b0;
         end else if (bus.load) begin
            r_pendVal <= bus.value_in;
            r_pendDp  <= bus.dp_in;
            r_pendEn  <= bus.en_in;
            r_pending <= 1'b1;
         end
         r_frameStart <= w_wrap;
         r_an         <= w_lit[w_nextIndex] ? ~(AN_ONE << w_nextIndex) : '1;
         r_seg        <= w_lit[w_nextIndex] ? w_digitSeg : SEG_BLANK;
         r_dp         <= w_lit[w_nextIndex] ? ~w_nextDp[w_nextIndex] : 1'b1;
      end
   end

   assign bus.an          = r_an;
   assign bus.seg         = r_seg;
   assign bus.dp          = r_dp;
   assign bus.frame_start = r_frameStart;
   assign bus.pending     = r_pending;

endmodule
